// File: rtl/axi_rd_arb_pkg.sv
// Shared definitions for the two-requester AXI read arbiter:
// FSM encodings, requester count, counter width and source-tag position.
package axi_rd_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_HOLD = 2'b10
    } arb_state_e;

    function automatic int src_tag_pos(input int id_w);
        return id_w - 1;
    endfunction

endpackage

// File: rtl/axi_rd_arb_cnt.sv
// Saturating per-requester outstanding-read counter.
// avail is high while another read may be issued.
module axi_rd_arb_cnt
    import axi_rd_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             avail
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            count <= '0;
        end else if (inc && !dec && count < MAX_C) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign avail = (count < MAX_C);

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter, round-robin with a HOLD lock.
// Define AXI_RD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 6,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESET,

    input  logic                  rq0_ren,
    input  logic [ID_WIDTH-2:0]   rq0_arid,
    input  logic [2:0]            rq0_arsize,
    input  logic [ADDR_WIDTH-1:0] rq0_araddr,
    output logic                  rq0_raddr_ok,
    output logic [DATA_WIDTH-1:0] rq0_rdata,
    output logic [ID_WIDTH-2:0]   rq0_rid,
    output logic                  rq0_rdata_ok,
    input  logic                  rq0_data_resp,

    input  logic                  rq1_ren,
    input  logic [ID_WIDTH-2:0]   rq1_arid,
    input  logic [2:0]            rq1_arsize,
    input  logic [ADDR_WIDTH-1:0] rq1_araddr,
    output logic                  rq1_raddr_ok,
    output logic [DATA_WIDTH-1:0] rq1_rdata,
    output logic [ID_WIDTH-2:0]   rq1_rid,
    output logic                  rq1_rdata_ok,
    input  logic                  rq1_data_resp,

    output logic                  m_ren,
    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [2:0]            m_arsize,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    input  logic                  m_raddr_ok,
    input  logic [DATA_WIDTH-1:0] m_sram_rdata,
    input  logic [ID_WIDTH-1:0]   m_rid,
    input  logic                  m_rdata_ok,
    output logic                  m_data_resp
);

    localparam int TAG = src_tag_pos(ID_WIDTH);

    arb_state_e           state;
    logic                 lock_gnt;
    logic                 gnt;
    logic                 active;
    logic                 src;
    logic [NUM_REQ-1:0]   ren;
    logic [NUM_REQ-1:0]   avail;
    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   aok;
    logic [NUM_REQ-1:0]   rok;
    logic [CNT_W-1:0]     cnt [NUM_REQ];

    assign ren  = {rq1_ren, rq0_ren};
    assign elig = ren & avail;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt    = 1'b0;
        active = 1'b0;
        if (state == ST_HOLD) begin
            gnt    = lock_gnt;
            active = 1'b1;
        end else begin
            gnt    = !elig[0];
            active = |elig;
        end
    end
`else
    logic last_gnt;

    // On a tie, favour whoever was not accepted last.
    always_comb begin
        gnt    = 1'b0;
        active = 1'b0;
        if (state == ST_HOLD) begin
            gnt    = lock_gnt;
            active = 1'b1;
        end else begin
            gnt    = (&elig) ? !last_gnt : !elig[0];
            active = |elig;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            last_gnt <= 1'b1;
        end else if (m_ren && m_raddr_ok) begin
            last_gnt <= gnt;
        end
    end
`endif

    assign m_ren = active && !ARESET;

    always_comb begin
        m_arid   = '0;
        m_arsize = '0;
        m_araddr = '0;
        if (m_ren) begin
            m_arid   = gnt ? {1'b1, rq1_arid} : {1'b0, rq0_arid};
            m_arsize = gnt ? rq1_arsize : rq0_arsize;
            m_araddr = gnt ? rq1_araddr : rq0_araddr;
        end
    end

    assign aok[0]       = m_raddr_ok && m_ren && !gnt;
    assign aok[1]       = m_raddr_ok && m_ren && gnt;
    assign rq0_raddr_ok = aok[0];
    assign rq1_raddr_ok = aok[1];

    // Responses are steered purely by the tag bit, even in reset.
    assign src          = m_rid[TAG];
    assign rok[0]       = m_rdata_ok && !src;
    assign rok[1]       = m_rdata_ok && src;
    assign rq0_rdata_ok = rok[0];
    assign rq1_rdata_ok = rok[1];
    assign rq0_rdata    = m_sram_rdata;
    assign rq1_rdata    = m_sram_rdata;
    assign rq0_rid      = m_rid[TAG-1:0];
    assign rq1_rid      = m_rid[TAG-1:0];
    assign m_data_resp  = src ? rq1_data_resp : rq0_data_resp;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state    <= ST_IDLE;
            lock_gnt <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (m_ren && !m_raddr_ok) begin
                        state    <= ST_HOLD;
                        lock_gnt <= gnt;
                    end
                end
                ST_HOLD: begin
                    if (m_raddr_ok) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        axi_rd_arb_cnt #(
            .MAX_OUTSTANDING(MAX_OUTSTANDING)
        ) u_cnt (
            .ACLK  (ACLK),
            .ARESET(ARESET),
            .inc   (aok[g]),
            .dec   (rok[g]),
            .count (cnt[g]),
            .avail (avail[g])
        );
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with a cycle-level reference model.
// Honours AXI_RD_ARB_FIXED_PRIO_EN for the fixed-priority build.
module tb_axi_rd_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int IW   = 6;
    localparam int MAXO = 2;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          rq0_ren, rq1_ren;
    logic [IW-2:0] rq0_arid, rq1_arid;
    logic [2:0]    rq0_arsize, rq1_arsize;
    logic [AW-1:0] rq0_araddr, rq1_araddr;
    logic          rq0_raddr_ok, rq1_raddr_ok;
    logic [DW-1:0] rq0_rdata, rq1_rdata;
    logic [IW-2:0] rq0_rid, rq1_rid;
    logic          rq0_rdata_ok, rq1_rdata_ok;
    logic          rq0_data_resp, rq1_data_resp;
    logic          m_ren;
    logic [IW-1:0] m_arid;
    logic [2:0]    m_arsize;
    logic [AW-1:0] m_araddr;
    logic          m_raddr_ok;
    logic [DW-1:0] m_sram_rdata;
    logic [IW-1:0] m_rid;
    logic          m_rdata_ok;
    logic          m_data_resp;

    int n_chk  = 0;
    int n_fail = 0;

    axi_rd_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .rq0_ren(rq0_ren), .rq0_arid(rq0_arid),
        .rq0_arsize(rq0_arsize), .rq0_araddr(rq0_araddr),
        .rq0_raddr_ok(rq0_raddr_ok), .rq0_rdata(rq0_rdata),
        .rq0_rid(rq0_rid), .rq0_rdata_ok(rq0_rdata_ok),
        .rq0_data_resp(rq0_data_resp),
        .rq1_ren(rq1_ren), .rq1_arid(rq1_arid),
        .rq1_arsize(rq1_arsize), .rq1_araddr(rq1_araddr),
        .rq1_raddr_ok(rq1_raddr_ok), .rq1_rdata(rq1_rdata),
        .rq1_rid(rq1_rid), .rq1_rdata_ok(rq1_rdata_ok),
        .rq1_data_resp(rq1_data_resp),
        .m_ren(m_ren), .m_arid(m_arid), .m_arsize(m_arsize),
        .m_araddr(m_araddr), .m_raddr_ok(m_raddr_ok),
        .m_sram_rdata(m_sram_rdata), .m_rid(m_rid),
        .m_rdata_ok(m_rdata_ok), .m_data_resp(m_data_resp)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: outstanding counts, lock and last winner.
    int mcnt [2] = '{0, 0};
    bit mhold = 0;
    int mlock = 0;
    int mlast = 1;

    always @(negedge ACLK) begin : cmp
        bit e0, e1, ren_e, a0, a1, r0, r1;
        int g, s;
        logic [IW-1:0] xid;
        logic [AW-1:0] xaddr;
        logic [2:0]    xsize;
        e0 = rq0_ren && (mcnt[0] < MAXO);
        e1 = rq1_ren && (mcnt[1] < MAXO);
        ren_e = 0;
        g = 0;
        if (!ARESET) begin
            if (mhold) begin
                ren_e = 1; g = mlock;
            end else if (e0 && e1) begin
                ren_e = 1;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
                g = 0;
`else
                g = 1 - mlast;
`endif
            end else if (e0) begin
                ren_e = 1; g = 0;
            end else if (e1) begin
                ren_e = 1; g = 1;
            end
        end
        xid = '0; xaddr = '0; xsize = '0;
        if (ren_e) begin
            xid   = (g == 1) ? {1'b1, rq1_arid} : {1'b0, rq0_arid};
            xaddr = (g == 1) ? rq1_araddr : rq0_araddr;
            xsize = (g == 1) ? rq1_arsize : rq0_arsize;
        end
        a0 = m_raddr_ok && ren_e && g == 0;
        a1 = m_raddr_ok && ren_e && g == 1;
        s  = int'(m_rid[IW-1]);
        r0 = m_rdata_ok && s == 0;
        r1 = m_rdata_ok && s == 1;
        chk("m_ren", m_ren, ren_e);
        chk("m_arid", m_arid, xid);
        chk("m_araddr", m_araddr, xaddr);
        chk("m_arsize", m_arsize, xsize);
        chk("rq0_raddr_ok", rq0_raddr_ok, a0);
        chk("rq1_raddr_ok", rq1_raddr_ok, a1);
        chk("rq0_rdata_ok", rq0_rdata_ok, r0);
        chk("rq1_rdata_ok", rq1_rdata_ok, r1);
        chk("m_data_resp", m_data_resp,
            s == 1 ? rq1_data_resp : rq0_data_resp);
        chk("dst_rdata", s == 1 ? rq1_rdata : rq0_rdata, m_sram_rdata);
        chk("dst_rid", s == 1 ? rq1_rid : rq0_rid, m_rid[IW-2:0]);
        if (!ARESET) begin
            chk("state", dut.state, mhold ? 2'b10 : 2'b01);
            chk("cnt0", dut.cnt[0], mcnt[0]);
            chk("cnt1", dut.cnt[1], mcnt[1]);
        end
        // Advance the model to what the coming rising edge commits.
        if (ARESET) begin
            mcnt[0] = 0; mcnt[1] = 0;
            mhold = 0; mlock = 0; mlast = 1;
        end else begin
            if (a0 && !r0 && mcnt[0] < MAXO) mcnt[0]++;
            if (r0 && !a0 && mcnt[0] > 0)    mcnt[0]--;
            if (a1 && !r1 && mcnt[1] < MAXO) mcnt[1]++;
            if (r1 && !a1 && mcnt[1] > 0)    mcnt[1]--;
            if (ren_e && !m_raddr_ok) begin
                mhold = 1; mlock = g;
            end else if (ren_e && m_raddr_ok) begin
                mhold = 0; mlast = g;
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clr();
        rq0_ren = 0; rq0_arid = '0; rq0_arsize = '0; rq0_araddr = '0;
        rq1_ren = 0; rq1_arid = '0; rq1_arsize = '0; rq1_araddr = '0;
        rq0_data_resp = 0; rq1_data_resp = 0;
        m_raddr_ok = 0; m_sram_rdata = '0; m_rid = '0; m_rdata_ok = 0;
    endtask

    task automatic do_reset();
        ARESET = 1;
        clr();
        tick();
        ARESET = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_g [4];
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        ARESET = 1;
        clr();
        rq0_ren = 1; m_raddr_ok = 1;
        @(negedge ACLK);
        chk("rst_m_ren", m_ren, 1'b0);
        chk("rst_raddr_ok", rq0_raddr_ok, 1'b0);
        tick();
        ARESET = 0;
        clr();

        // Single request accepted in the same cycle.
        rq0_ren = 1; rq0_araddr = 32'h100; rq0_arid = 5'd5;
        rq0_arsize = 3'd2; m_raddr_ok = 1;
        @(negedge ACLK);
        chk("s1_arid", m_arid, 6'b000101);
        chk("s1_araddr", m_araddr, 32'h100);
        chk("s1_raddr_ok", rq0_raddr_ok, 1'b1);
        tick();
        clr();
        @(negedge ACLK);
        chk("s1_cnt0", dut.cnt[0], 3'd1);
        chk("s1_state", dut.state, 2'b01);
        tick();

        // Both always requesting; rq0 data keeps its count flat.
        do_reset();
        rq0_ren = 1; rq0_araddr = 32'hA0; rq0_arid = 5'd1;
        rq1_ren = 1; rq1_araddr = 32'hB0; rq1_arid = 5'd2;
        m_raddr_ok = 1; m_rdata_ok = 1; m_rid = 6'b000001;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            chk("rr_grant", m_arid[IW-1], exp_g[i]);
            tick();
        end

        // Lock held for four cycles while rq0 waits.
        do_reset();
        rq1_ren = 1; rq1_araddr = 32'h2000; rq1_arid = 5'd7;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                rq0_ren = 1; rq0_araddr = 32'h1000;
            end
            m_raddr_ok = (i == 3);
            @(negedge ACLK);
            chk("hold_araddr", m_araddr, 32'h2000);
            chk("hold_rq0_ok", rq0_raddr_ok, 1'b0);
            tick();
        end
        rq1_ren = 0;
        @(negedge ACLK);
        chk("hold_next_addr", m_araddr, 32'h1000);
        chk("hold_next_ok", rq0_raddr_ok, 1'b1);
        tick();
        clr();

        // Outstanding limit reached, released by data return.
        do_reset();
        rq0_ren = 1; rq0_araddr = 32'h300; m_raddr_ok = 1;
        tick();
        tick();
        @(negedge ACLK);
        chk("lim_block", m_ren, 1'b0);
        tick();
        m_rid = 6'b000000; m_rdata_ok = 1;
        @(negedge ACLK);
        chk("lim_ret_block", m_ren, 1'b0);
        chk("lim_ret_ok", rq0_rdata_ok, 1'b1);
        tick();
        m_rdata_ok = 0;
        @(negedge ACLK);
        chk("lim_regrant", m_ren, 1'b1);
        chk("lim_regrant_ok", rq0_raddr_ok, 1'b1);
        tick();
        clr();

        // Response routing and same-cycle accept plus return.
        do_reset();
        m_rid = 6'b100011; m_rdata_ok = 1;
        m_sram_rdata = 32'hDEADBEEF; rq1_data_resp = 1;
        @(negedge ACLK);
        chk("rt_rdata", rq1_rdata, 32'hDEADBEEF);
        chk("rt_rid", rq1_rid, 5'd3);
        chk("rt_rq0_ok", rq0_rdata_ok, 1'b0);
        chk("rt_rq1_ok", rq1_rdata_ok, 1'b1);
        chk("rt_resp", m_data_resp, 1'b1);
        tick();
        clr();
        rq1_ren = 1; rq1_araddr = 32'h500; m_raddr_ok = 1;
        tick();
        m_rid = 6'b100000; m_rdata_ok = 1;
        tick();
        clr();
        @(negedge ACLK);
        chk("same_cyc_cnt1", dut.cnt[1], 3'd1);
        tick();

        // Reset while locked discards the lock.
        do_reset();
        rq0_ren = 1; rq0_araddr = 32'h400;
        tick();
        @(negedge ACLK);
        chk("r_hold_state", dut.state, 2'b10);
        ARESET = 1;
        rq1_ren = 1; rq1_araddr = 32'h600;
        @(negedge ACLK);
        chk("r_rst_m_ren", m_ren, 1'b0);
        tick();
        ARESET = 0;
        rq0_ren = 0;
        @(negedge ACLK);
        chk("r_state", dut.state, 2'b01);
        chk("r_cnt0", dut.cnt[0], 3'd0);
        chk("r_m_ren", m_ren, 1'b1);
        chk("r_grant", m_arid[IW-1], 1'b1);
        tick();
        clr();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
